// File: rtl/uart_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_frame_pkg                                             |
// | Description : Shared types and constants for the UART frame parser:      |
// |               FSM state encoding, error code values, default header.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHK     = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_OVERRUN = 2'd0;
   localparam err_code_t ERR_BADLEN  = 2'd1;
   localparam err_code_t ERR_CHK     = 2'd2;
   localparam err_code_t ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_frame_parser_if                                       |
// | Description : Byte-strobe input and payload stream output of the frame   |
// |               parser, plus its error/status flags.                       |
// |   uart_done/uart_data : received byte strobe and value                   |
// |   out_data/out_valid/out_ready/out_last : payload stream                 |
// |   frame_err/err_code  : error pulse and sticky error code                |
// |   busy                : parser not in IDLE                               |
// |   master : byte source + stream sink side                                |
// |   slave  : the parser                                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface uart_frame_parser_if;
   import uart_frame_pkg::*;

   logic       uart_done;
   logic [7:0] uart_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_err;
   err_code_t  err_code;
   logic       busy;

   modport master (
      output uart_done, uart_data, out_ready,
      input  out_data, out_valid, out_last, frame_err, err_code, busy
   );

   modport slave (
      input  uart_done, uart_data, out_ready,
      output out_data, out_valid, out_last, frame_err, err_code, busy
   );

endinterface
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_frame_buf                                             |
// | Description : DEPTH x WIDTH register array, one synchronous write port   |
// |               and one asynchronous read port. No reset: contents are     |
// |               only meaningful after being written for the current frame. |
// |   clk                        : clock                                     |
// |   wr_en/wr_addr/wr_data      : write port                                |
// |   rd_addr/rd_data            : combinational read port                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_frame_buf #(
   parameter  int DEPTH  = 16,
   parameter  int WIDTH  = 8,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_frame_parser                                          |
// | Description : Assembles HEADER, LEN, payload, CHK frames from a UART     |
// |               byte strobe. The payload is buffered and released on a     |
// |               valid/ready stream only once the checksum matches.         |
// |               Checksum = (LEN + sum of payload bytes) mod 256.           |
// |   sys_clk : clock                                                        |
// |   sys_rst : synchronous active-high reset                                |
// |   bus     : uart_frame_parser_if.slave (byte in, stream out, status)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] HEADER      = DEFAULT_HEADER,
   parameter int         MAX_LEN     = 16,     // 1..255
   parameter int         TIMEOUT_CYC = 50000   // >= 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   uart_frame_parser_if.slave   bus
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   // The error fires on the cycle the counter would step to TIMEOUT_CYC-1,
   // so the pulse lands exactly TIMEOUT_CYC cycles after the last strobe.
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC - 2);

   state_t            state_q,     state_d;
   logic [LEN_W-1:0]  len_q,       len_d;
   logic [7:0]        sum_q,       sum_d;
   logic [IDX_W-1:0]  wr_idx_q,    wr_idx_d;
   logic [IDX_W-1:0]  rd_idx_q,    rd_idx_d;
   logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
   logic              frame_err_q, frame_err_d;
   err_code_t         err_code_q,  err_code_d;

   logic              buf_we;
   logic [7:0]        buf_rdata;
   logic              len_ok;
   logic              wr_last;
   logic              rd_last;
   logic              draining;

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .WIDTH (8)
   ) u_buf (
      .clk     (sys_clk),
      .wr_en   (buf_we),
      .wr_addr (wr_idx_q),
      .wr_data (bus.uart_data),
      .rd_addr (rd_idx_q),
      .rd_data (buf_rdata)
   );

   assign len_ok   = (bus.uart_data != 8'd0) &&
                     (int'({24'd0, bus.uart_data}) <= MAX_LEN);
   assign wr_last  = (LEN_W'(wr_idx_q) == (len_q - LEN_W'(1)));
   assign rd_last  = (LEN_W'(rd_idx_q) == (len_q - LEN_W'(1)));
   assign draining = (state_q == ST_DRAIN);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      sum_d       = sum_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      to_cnt_d    = '0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      buf_we      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.uart_done && (bus.uart_data == HEADER)) begin
               state_d = ST_LEN;
            end
         end

         ST_LEN: begin
            if (bus.uart_done) begin
               if (len_ok) begin
                  len_d    = LEN_W'(bus.uart_data);
                  sum_d    = bus.uart_data;
                  wr_idx_d = '0;
                  state_d  = ST_PAYLOAD;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_BADLEN;
                  state_d     = ST_IDLE;
               end
            end
         end

         ST_PAYLOAD: begin
            if (bus.uart_done) begin
               buf_we   = 1'b1;
               sum_d    = sum_q + bus.uart_data;
               wr_idx_d = wr_idx_q + IDX_W'(1);
               if (wr_last) begin
                  state_d = ST_CHK;
               end
            end
         end

         ST_CHK: begin
            if (bus.uart_done) begin
               if (bus.uart_data == sum_q) begin
                  rd_idx_d = '0;
                  state_d  = ST_DRAIN;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
                  state_d     = ST_IDLE;
               end
            end
         end

         ST_DRAIN: begin
            // A byte arriving now has nowhere to go; drop it, keep draining.
            if (bus.uart_done) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_OVERRUN;
            end
            if (bus.out_ready) begin
               if (rd_last) begin
                  rd_idx_d = '0;
                  state_d  = ST_IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + IDX_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Inter-byte watchdog; a strobe in the expiry cycle wins.
      if ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK)) begin
         if (!bus.uart_done) begin
            if (to_cnt_q == TO_LIMIT) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
               state_d     = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         sum_q       <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_OVERRUN;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         sum_q       <= sum_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_valid = draining;
   assign bus.out_last  = draining && rd_last;
   assign bus.out_data  = draining ? buf_rdata : 8'h00;
   assign bus.frame_err = frame_err_q;
   assign bus.err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_frame_parser                                       |
// | Description : Self-checking bench for uart_frame_parser: directed        |
// |               vector table, cycle-exact corner sequences and random      |
// |               frames scored against a stream-level reference parser.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_frame_parser;
   import uart_frame_pkg::*;

   localparam int         MAX_LEN     = 16;
   localparam int         TIMEOUT_CYC = 20;
   localparam logic [7:0] HDR         = 8'hA5;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      int           n;       // bytes to send
      logic [159:0] b;       // byte 0 in the most significant used lane
      int           n_out;   // payload bytes expected out
      logic [127:0] o;
      int           err;     // expected error code, -1 for none
   } vec_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   int   ready_mode = 0;     // 0: always ready, 1: 1,0,0,1 pattern, 2: random

   logic [8:0] got_data[$];  // {last, data}
   logic [1:0] got_err[$];
   logic [8:0] exp_data[$];
   logic [1:0] exp_err[$];

   logic       prev_stall = 1'b0;
   logic       prev_err   = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   logic       prev_last  = 1'b0;

   vec_t vecs[7];

   uart_frame_parser_if bus();

   uart_frame_parser #(
      .HEADER      (HDR),
      .MAX_LEN     (MAX_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: handshakes, error pulses, stall stability, pulse width.
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         prev_stall <= 1'b0;
         prev_err   <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.out_data), 32'(prev_data));
            check("stall_last", 32'(bus.out_last), 32'(prev_last));
         end
         if (bus.frame_err) begin
            check("err_single_cycle", 32'(prev_err), 32'd0);
            got_err.push_back(bus.err_code);
         end
         if (bus.out_valid && bus.out_ready) begin
            got_data.push_back({bus.out_last, bus.out_data});
         end
         prev_stall <= bus.out_valid && !bus.out_ready;
         prev_data  <= bus.out_data;
         prev_last  <= bus.out_last;
         prev_err   <= bus.frame_err;
      end
   end

   initial begin : ready_drv
      int ph;
      ph = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         case (ready_mode)
            1:       bus.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            2:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b1;
         endcase
         ph++;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   // Reference: scan the byte stream for frames and predict results.
   function automatic void model(input byte_q_t s);
      int i;
      int len;
      int sum;
      i = 0;
      while (i < s.size()) begin
         if (s[i] != HDR) begin
            i++;
            continue;
         end
         if (i + 1 >= s.size()) break;
         len = int'(s[i+1]);
         if (len == 0 || len > MAX_LEN) begin
            exp_err.push_back(ERR_BADLEN);
            i += 2;
            continue;
         end
         if (i + 2 + len >= s.size()) break;
         sum = len;
         for (int j = 0; j < len; j++) sum = (sum + int'(s[i+2+j])) % 256;
         if (int'(s[i+2+len]) == sum) begin
            for (int j = 0; j < len; j++) exp_data.push_back({(j == len - 1), s[i+2+j]});
         end else begin
            exp_err.push_back(ERR_CHK);
         end
         i += 3 + len;
      end
   endfunction

   // Called at posedge+1; strobes for one cycle, returns at next posedge+1.
   task automatic send_byte(input logic [7:0] b);
      bus.uart_done = 1'b1;
      bus.uart_data = b;
      @(posedge sys_clk);
      #1;
      bus.uart_done = 1'b0;
      bus.uart_data = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((bus.busy || bus.out_valid) && k < 1000) begin
         @(posedge sys_clk);
         #1;
         k++;
      end
      check({tag, "_idle_bound"}, 32'(k < 1000), 32'd1);
      idle(2);
   endtask

   task automatic compare(input string tag);
      check({tag, "_nbytes"}, 32'(got_data.size()), 32'(exp_data.size()));
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         check({tag, "_byte"}, 32'(got_data[i]), 32'(exp_data[i]));
      end
      check({tag, "_nerr"}, 32'(got_err.size()), 32'(exp_err.size()));
      for (int i = 0; i < exp_err.size() && i < got_err.size(); i++) begin
         check({tag, "_errcode"}, 32'(got_err[i]), 32'(exp_err[i]));
      end
      got_data.delete();
      got_err.delete();
      exp_data.delete();
      exp_err.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
      check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
      check({tag, "_err_code"},  32'(bus.err_code),  32'd0);
      check({tag, "_busy"},      32'(bus.busy),      32'd0);
   endtask

   initial begin : main
      byte_q_t s;
      int      kind;
      int      len;
      logic [7:0] sum;
      logic [7:0] b;

      // ---------------- directed vector table ----------------
      vecs[0] = '{6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}),
                  3, 128'({8'h11, 8'h22, 8'h33}), -1};
      vecs[1] = '{6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67}),
                  0, 128'd0, 2};
      vecs[2] = '{2, 160'({8'hA5, 8'h00}), 0, 128'd0, 1};
      vecs[3] = '{2, 160'({8'hA5, 8'h11}), 0, 128'd0, 1};
      vecs[4] = '{6, 160'({8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F}),
                  1, 128'({8'h7E}), -1};
      vecs[5] = '{19, 160'd0, 16, 128'd0, -1};
      vecs[5].b[8*18 +: 8] = HDR;
      vecs[5].b[8*17 +: 8] = 8'h10;
      for (int i = 0; i < 16; i++) begin
         vecs[5].b[8*(16-i) +: 8] = 8'(i + 1);
         vecs[5].o[8*(15-i) +: 8] = 8'(i + 1);
      end
      vecs[5].b[7:0] = 8'h98;
      vecs[6] = '{5, 160'({8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA8}),
                  2, 128'({8'hA5, 8'h01}), -1};

      bus.uart_done = 1'b0;
      bus.uart_data = 8'h00;
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      check_idle_outputs("reset");
      sys_rst = 1'b0;
      idle(1);

      // ---------------- latency / back-to-back drain ----------------
      ready_mode = 0;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33);
      @(negedge sys_clk);
      check("lat_in_chk_valid", 32'(bus.out_valid), 32'd0);
      check("lat_in_chk_busy",  32'(bus.busy),      32'd1);
      send_byte(8'h69);
      @(negedge sys_clk);
      check("lat_b0_valid", 32'(bus.out_valid), 32'd1);
      check("lat_b0_data",  32'(bus.out_data),  32'h11);
      check("lat_b0_last",  32'(bus.out_last),  32'd0);
      @(negedge sys_clk);
      check("lat_b1_data",  32'(bus.out_data),  32'h22);
      @(negedge sys_clk);
      check("lat_b2_data",  32'(bus.out_data),  32'h33);
      check("lat_b2_last",  32'(bus.out_last),  32'd1);
      @(negedge sys_clk);
      check("lat_end_valid", 32'(bus.out_valid), 32'd0);
      check("lat_end_busy",  32'(bus.busy),      32'd0);
      @(posedge sys_clk);
      #1;
      exp_data = '{9'h011, 9'h022, 9'h133};
      compare("lat");

      // ---------------- checksum error pulse ----------------
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h67);
      @(negedge sys_clk);
      check("chk_err_pulse", 32'(bus.frame_err), 32'd1);
      check("chk_err_code",  32'(bus.err_code),  32'd2);
      check("chk_err_valid", 32'(bus.out_valid), 32'd0);
      check("chk_err_busy",  32'(bus.busy),      32'd0);
      @(negedge sys_clk);
      check("chk_err_clear", 32'(bus.frame_err), 32'd0);
      @(posedge sys_clk);
      #1;
      exp_err.push_back(2'd2);
      compare("chk");

      // ---------------- table ----------------
      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            send_byte(vecs[v].b[8*(vecs[v].n-1-i) +: 8]);
         end
         wait_idle($sformatf("vec%0d", v));
         for (int i = 0; i < vecs[v].n_out; i++) begin
            exp_data.push_back({(i == vecs[v].n_out - 1), vecs[v].o[8*(vecs[v].n_out-1-i) +: 8]});
         end
         if (vecs[v].err >= 0) exp_err.push_back(2'(vecs[v].err));
         compare($sformatf("vec%0d", v));
      end

      // ---------------- timeout, exact cycle ----------------
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
      begin
         int early;
         early = 0;
         for (int k = 1; k < TIMEOUT_CYC; k++) begin
            @(negedge sys_clk);
            if (bus.frame_err) early++;
         end
         check("timeout_early", 32'(early), 32'd0);
      end
      @(negedge sys_clk);
      check("timeout_pulse", 32'(bus.frame_err), 32'd1);
      check("timeout_code",  32'(bus.err_code),  32'd3);
      check("timeout_busy",  32'(bus.busy),      32'd0);
      @(posedge sys_clk);
      #1;
      exp_err.push_back(2'd3);
      compare("timeout");

      // ---------------- byte in the expiry cycle cancels timeout ----------------
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
      idle(TIMEOUT_CYC - 2);
      send_byte(8'h02);
      send_byte(8'h05);
      wait_idle("tcancel");
      exp_data = '{9'h001, 9'h102};
      compare("tcancel");

      // ---------------- reset mid-payload ----------------
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
      check("rst_pre_busy", 32'(bus.busy), 32'd1);
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      check_idle_outputs("rst_mid");
      sys_rst = 1'b0;
      got_data.delete();
      got_err.delete();
      idle(1);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      wait_idle("rst_after");
      exp_data = '{9'h17E};
      compare("rst_after");

      // ---------------- overrun during a stalled drain ----------------
      ready_mode = 1;
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'hC1);
      send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4); send_byte(8'h0E);
      send_byte(8'h5A);
      wait_idle("overrun");
      exp_data = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
      exp_err.push_back(2'd0);
      compare("overrun");

      // ---------------- random frames vs reference ----------------
      for (int f = 0; f < 40; f++) begin
         s.delete();
         ready_mode = $urandom_range(0, 2);
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h00;
            s.push_back(b);
         end
         s.push_back(HDR);
         kind = $urandom_range(0, 3);
         if (kind == 1) begin
            if ($urandom_range(0, 1) == 1) s.push_back(8'h00);
            else s.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
         end else begin
            len = $urandom_range(1, MAX_LEN);
            s.push_back(8'(len));
            sum = 8'(len);
            for (int j = 0; j < len; j++) begin
               b = 8'($urandom_range(0, 255));
               sum = sum + b;
               s.push_back(b);
            end
            if (kind == 2) s.push_back(sum ^ (8'h01 << $urandom_range(0, 7)));
            else s.push_back(sum);
         end
         model(s);
         foreach (s[i]) begin
            send_byte(s[i]);
            idle($urandom_range(0, 3));
         end
         wait_idle("rand");
         compare($sformatf("rand%0d", f));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
